// File: rtl/otbn_pkg.sv
// Shared types for the OTBN base-subset multiply/divide sequencer and the base ALU interface.
package otbn_pkg;

  localparam int MuldivIterations = 32;

  typedef enum logic [1:0] {
    MdOpMul  = 2'd0,
    MdOpDivu = 2'd1,
    MdOpRemu = 2'd2
  } muldiv_op_e;

  typedef enum logic [1:0] {
    MdIdle = 2'd0,
    MdBusy = 2'd1,
    MdDone = 2'd2
  } muldiv_state_e;

  typedef enum logic [3:0] {
    AluOpBaseAdd = 4'd0,
    AluOpBaseSub = 4'd1,
    AluOpBaseXor = 4'd2,
    AluOpBaseOr  = 4'd3,
    AluOpBaseAnd = 4'd4,
    AluOpBaseNot = 4'd5
  } alu_base_op_e;

  typedef struct packed {
    alu_base_op_e op;
    logic [31:0]  operand_a;
    logic [31:0]  operand_b;
  } alu_base_operation_t;

endpackage

// File: rtl/otbn_alu_base_muldiv_seq.sv
// Constant-time shift-add multiplier and restoring divider that borrows otbn_alu_base
// for its one add/subtract per iteration.
module otbn_alu_base_muldiv_seq
  import otbn_pkg::*;
#(
  parameter int NumIter = MuldivIterations
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  muldiv_op_e          req_op_i,
  input  logic [31:0]         req_operand_a_i,
  input  logic [31:0]         req_operand_b_i,
  output alu_base_operation_t alu_operation_o,
  input  logic [31:0]         alu_result_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [31:0]         rsp_result_o,
  output logic                busy_o
);

  if (NumIter != 32) begin : gen_bad_num_iter
    $fatal(1, "otbn_alu_base_muldiv_seq: NumIter must be 32");
  end

  localparam logic [4:0] LastCnt = 5'(NumIter - 1);

  muldiv_state_e state_q, state_d;
  muldiv_op_e    op_q;
  logic [4:0]    cnt_q;
  // r_q is acc (MUL) or rem (DIV); s_q is mcand (MUL) or quo (DIV); b_q is mplier or divisor.
  logic [31:0]   r_q, s_q, a_q, b_q, result_q;
  logic [31:0]   r_n, s_n, res_n, tmp;
  logic          is_mul, last, ge;

  assign is_mul = (op_q == MdOpMul);
  assign last   = (cnt_q == LastCnt);
  assign tmp    = {r_q[30:0], s_q[31]};
  assign ge     = (tmp >= b_q);

  always_comb begin
    r_n   = r_q;
    s_n   = s_q;
    res_n = r_q;
    if (is_mul) begin
      r_n = b_q[cnt_q] ? alu_result_i : r_q;
      s_n = {s_q[30:0], 1'b0};
    end else begin
      r_n = ge ? alu_result_i : tmp;
      s_n = {s_q[30:0], ge};
    end
    res_n = (op_q == MdOpDivu) ? s_n : r_n;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= MdIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    req_ready_o     = 1'b0;
    rsp_valid_o     = 1'b0;
    busy_o          = 1'b1;
    alu_operation_o = '{op: AluOpBaseAdd, operand_a: 32'd0, operand_b: 32'd0};
    case (state_q)
      MdIdle: begin
        req_ready_o = 1'b1;
        busy_o      = 1'b0;
        if (req_valid_i) state_d = MdBusy;
      end
      MdBusy: begin
        if (is_mul) begin
          alu_operation_o = '{op: AluOpBaseAdd, operand_a: r_q, operand_b: s_q};
        end else begin
          alu_operation_o = '{op: AluOpBaseSub, operand_a: tmp, operand_b: b_q};
        end
        if (last) state_d = MdDone;
      end
      MdDone: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = MdIdle;
      end
      default: state_d = MdIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q     <= MdOpMul;
      cnt_q    <= '0;
      r_q      <= '0;
      s_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        MdIdle: begin
          if (req_valid_i) begin
            op_q  <= req_op_i;
            a_q   <= req_operand_a_i;
            b_q   <= req_operand_b_i;
            cnt_q <= '0;
            r_q   <= '0;
            s_q   <= req_operand_a_i;
          end
        end
        MdBusy: begin
          r_q   <= r_n;
          s_q   <= s_n;
          cnt_q <= cnt_q + 5'd1;
          if (last) result_q <= res_n;
        end
        default: ;
      endcase
    end
  end

  assign rsp_result_o = result_q;

  // Division by zero is expected to fall out of the datapath naturally, so it is checked, not muxed.
  assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == MdBusy && last && !is_mul && b_q == 32'd0) |-> (s_n == 32'hFFFF_FFFF && r_n == a_q));

  assert property (@(posedge clk_i) disable iff (!rst_ni)
    (rsp_valid_o && !rsp_ready_i) |=> $stable(rsp_result_o));

  assert property (@(posedge clk_i) disable iff (!rst_ni) !(req_ready_o && rsp_valid_o));

  assert property (@(posedge clk_i) disable iff (!rst_ni) !$isunknown(alu_operation_o));

endmodule

// File: tb/tb_otbn_alu_base_muldiv_seq.sv
// Directed bench for otbn_alu_base_muldiv_seq with a behavioural base ALU and a result scoreboard.
module tb_otbn_alu_base_muldiv_seq;
  import otbn_pkg::*;

  logic                clk_i = 1'b0;
  logic                rst_ni = 1'b0;
  logic                req_valid_i = 1'b0;
  logic                req_ready_o;
  muldiv_op_e          req_op_i = MdOpMul;
  logic [31:0]         req_operand_a_i = '0;
  logic [31:0]         req_operand_b_i = '0;
  alu_base_operation_t alu_operation_o;
  logic [31:0]         alu_result_i;
  logic                rsp_valid_o;
  logic                rsp_ready_i = 1'b1;
  logic [31:0]         rsp_result_o;
  logic                busy_o;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  localparam logic [67:0] AluIdle = {AluOpBaseAdd, 32'd0, 32'd0};

  otbn_alu_base_muldiv_seq dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_operand_a_i(req_operand_a_i), .req_operand_b_i(req_operand_b_i),
    .alu_operation_o(alu_operation_o), .alu_result_i(alu_result_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_result_o(rsp_result_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural stand-in for otbn_alu_base.
  always_comb begin
    case (alu_operation_o.op)
      AluOpBaseSub: alu_result_i = alu_operation_o.operand_a - alu_operation_o.operand_b;
      default:      alu_result_i = alu_operation_o.operand_a + alu_operation_o.operand_b;
    endcase
  end

  task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".req_ready"}, 68'(req_ready_o), 68'd1);
    check({tag, ".rsp_valid"}, 68'(rsp_valid_o), 68'd0);
    check({tag, ".rsp_result"}, 68'(rsp_result_o), 68'd0);
    check({tag, ".busy"}, 68'(busy_o), 68'd0);
    check({tag, ".alu_op"}, 68'(alu_operation_o), AluIdle);
  endtask

  // Handshake one command; leaves the bench one edge past the handshake (first BUSY cycle).
  task automatic applyStimulus(input muldiv_op_e op, input logic [31:0] a, input logic [31:0] b);
    req_op_i        = op;
    req_operand_a_i = a;
    req_operand_b_i = b;
    req_valid_i     = 1'b1;
    check("req_ready_before_hs", 68'(req_ready_o), 68'd1);
    @(posedge clk_i); #1;
    req_valid_i     = 1'b0;
    req_operand_a_i = 32'hDEAD_BEEF;
    req_operand_b_i = 32'h1234_5678;
  endtask

  // Track BUSY until rsp_valid_o, then compare latency and the scoreboard entry.
  task automatic checkOutput(input string tag, input alu_base_op_e busy_op, input int stall);
    int lat;
    logic [31:0] expv;
    logic [31:0] held;
    int bad_op;
    lat = 0;
    bad_op = 0;
    while (!rsp_valid_o && lat < 40) begin
      if (alu_operation_o.op !== busy_op || busy_o !== 1'b1 || req_ready_o !== 1'b0) bad_op++;
      @(posedge clk_i); #1;
      lat++;
    end
    check({tag, ".latency"}, 68'(lat), 68'd32);
    check({tag, ".busy_cycles"}, 68'(bad_op), 68'd0);
    check({tag, ".done_alu_idle"}, 68'(alu_operation_o), AluIdle);
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("[TB] FAIL %s.scoreboard observed=empty expected=entry", tag);
    end
    expv = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hX;
    check({tag, ".result"}, 68'(rsp_result_o), 68'(expv));
    held = rsp_result_o;
    for (int i = 0; i < stall; i++) begin
      req_valid_i = 1'b1;
      req_op_i    = MdOpDivu;
      @(posedge clk_i); #1;
      check({tag, ".stall_valid"}, 68'(rsp_valid_o), 68'd1);
      check({tag, ".stall_stable"}, 68'(rsp_result_o), 68'(held));
      check({tag, ".stall_ready"}, 68'(req_ready_o), 68'd0);
    end
    req_valid_i = 1'b0;
    rsp_ready_i = 1'b1;
    @(posedge clk_i); #1;
    check({tag, ".idle_ready"}, 68'(req_ready_o), 68'd1);
    check({tag, ".idle_valid"}, 68'(rsp_valid_o), 68'd0);
    check({tag, ".idle_busy"}, 68'(busy_o), 68'd0);
  endtask

  task automatic run_cmd(input string tag, input muldiv_op_e op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expv, input int stall);
    if (stall > 0) rsp_ready_i = 1'b0;
    applyStimulus(op, a, b);
    exp_q.push_back(expv);
    checkOutput(tag, (op == MdOpMul) ? AluOpBaseAdd : AluOpBaseSub, stall);
  endtask

  initial begin
    int seen;
    #12;
    check_reset_outputs("reset_held");
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    check_reset_outputs("after_reset");

    run_cmd("mul_7x6",       MdOpMul,  32'd7,          32'd6,          32'h0000_002A, 0);
    run_cmd("mul_ffxff",     MdOpMul,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001, 0);
    run_cmd("mul_wrap",      MdOpMul,  32'h8000_0000,  32'd2,          32'h0000_0000, 0);
    run_cmd("divu_100_7",    MdOpDivu, 32'd100,        32'd7,          32'h0000_000E, 0);
    run_cmd("remu_100_7",    MdOpRemu, 32'd100,        32'd7,          32'h0000_0002, 0);
    run_cmd("divu_ff_ff",    MdOpDivu, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001, 0);
    run_cmd("remu_ff_ff",    MdOpRemu, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000, 0);
    run_cmd("divu_by_zero",  MdOpDivu, 32'd5,          32'd0,          32'hFFFF_FFFF, 0);
    run_cmd("remu_by_zero",  MdOpRemu, 32'd5,          32'd0,          32'h0000_0005, 0);
    run_cmd("backpressure",  MdOpMul,  32'd1234,       32'd1000,       32'd1234000,   5);

    // Abort a MUL at cnt==10 with an asynchronous reset.
    applyStimulus(MdOpMul, 32'd99, 32'd77);
    repeat (10) @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("mid_op_reset");
    @(posedge clk_i); #3;
    rst_ni = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_i); #1;
      if (rsp_valid_o) seen++;
    end
    check("no_rsp_after_abort", 68'(seen), 68'd0);
    check("scoreboard_empty", 68'(exp_q.size()), 68'd0);
    run_cmd("mul_3x3_after_reset", MdOpMul, 32'd3, 32'd3, 32'd9, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/otbn_alu_base_muldiv_seq.md
Name: otbn_alu_base_muldiv_seq

Overview:
- Iterative initiator for the base ALU operation interface. It accepts a multiply-low, unsigned-divide or unsigned-remainder command. Each cycle it issues one alu_base_operation_t to otbn_alu_base and consumes the combinational result.
- It sits between the OTBN base-subset controller and otbn_alu_base.
- It reuses the existing adder instead of adding a dedicated multiplier or divider.
- Every command takes a fixed, data-independent number of cycles (constant time).

Parameters:
- NumIter, 32, number of BUSY iterations. Fixed to the operand width. Anything other than 32 is illegal and is asserted at elaboration.

Ports:
- clk_i  input  1  clock
- rst_ni  input  1  reset; asynchronous, active-low
- req_valid_i  input  1  command valid
- req_ready_o  output  1  command accepted when valid and ready are both high
- req_op_i  input  2  muldiv_op_e: MdOpMul, MdOpDivu, MdOpRemu
- req_operand_a_i  input  32  multiplicand / dividend
- req_operand_b_i  input  32  multiplier / divisor
- alu_operation_o  output  alu_base_operation_t  operation driven to otbn_alu_base
- alu_result_i  input  32  operation_result_o returned from otbn_alu_base
- rsp_valid_o  output  1  result valid
- rsp_ready_i  input  1  result consumed when valid and ready are both high
- rsp_result_o  output  32  result
- busy_o  output  1  high in BUSY or DONE

Behaviour:
- One clock, clk_i. Reset rst_ni is asynchronous and active-low.
- Reset values of the outputs:
  - req_ready_o=1
  - rsp_valid_o=0
  - rsp_result_o=0
  - busy_o=0
  - alu_operation_o = {op=AluOpBaseAdd, operand_a=0, operand_b=0}
- Internal state resets to zero.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: req_ready_o=1. On a request handshake, latch op, a and b, clear cnt, and go to BUSY.
  - BUSY: runs cnt=0..31, one ALU operation per cycle. At cnt==31, update state and go to DONE.
  - DONE: rsp_valid_o=1. rsp_result_o is held stable until rsp_ready_i. On the response handshake, go to IDLE.
  - A new request is never accepted in the same cycle as a response handshake.
- Latency: handshake in cycle 0, BUSY in cycles 1..32, rsp_valid_o rises in cycle 33. This holds for every op and every operand value, including divide by zero.
- req_ready_o is low in BUSY and DONE. Inputs presented there are ignored.
- In IDLE and DONE, alu_operation_o holds its reset value so the ALU does not toggle.
- MUL datapath (acc, mcand, mplier):
  - Init: acc=0, mcand=a, mplier=b.
  - BUSY drives op=AluOpBaseAdd, operand_a=acc, operand_b=mcand.
  - Each iteration: if mplier[cnt], acc <= alu_result_i. Then mcand <= mcand<<1; the shift is local, not done in the ALU.
  - Result is acc (the low 32 bits of the product; overflow wraps).
- DIVU/REMU datapath, restoring division (rem, quo):
  - Init: rem=0, quo=a.
  - Each iteration: tmp = {rem[30:0], quo[31]}.
  - BUSY drives op=AluOpBaseSub, operand_a=tmp, operand_b=b.
  - If tmp >= b (local unsigned 32-bit compare): rem <= alu_result_i and quo <= {quo[30:0],1}.
  - Otherwise: rem <= tmp and quo <= {quo[30:0],0}.
  - No 33rd remainder bit is needed, because the remainder before iteration k is below 2^k, so tmp never overflows.
- Divide by zero:
  - Iterations still run.
  - At the transition to DONE, force the result: DIVU gives 0xFFFFFFFF, REMU gives a.
  - The natural datapath already yields these values; this is asserted, not muxed, if they are equal.
- Result selection: MUL gives acc, DIVU gives quo, REMU gives rem. The result is registered at the BUSY to DONE transition.
- Reset asserted mid-operation: return immediately to IDLE with reset output values. The in-flight command is dropped and no response is produced.
- Assertions:
  - rsp_result_o stable while rsp_valid_o is high and rsp_ready_i is low.
  - req_ready_o and rsp_valid_o are never both high.
  - No X on alu_operation_o after reset.

Decomposition:
- otbn_pkg:
  - muldiv_op_e enum (2 bits)
  - MuldivIterations=32
- alu_base_operation_t and alu_base_op_e are reused unchanged.
- Sub-modules: none required. Optionally, one otbn_muldiv_step combinational sub-module for the per-iteration next-state of acc/mcand or rem/quo; the FSM stays in the top.

Test Plan:
- MUL 7*6, rsp_ready_i=1 → rsp_valid_o rises exactly 33 cycles after the handshake, result 0x0000002A. alu_operation_o.op=AluOpBaseAdd throughout BUSY.
- MUL 0xFFFFFFFF*0xFFFFFFFF → 0x00000001; MUL 0x80000000*2 → 0x00000000 (wrap).
- DIVU 100/7 → 0x0000000E; REMU 100/7 → 0x00000002; DIVU 0xFFFFFFFF/0xFFFFFFFF → 1, REMU → 0. Each takes 33 cycles, op=AluOpBaseSub in BUSY.
- DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 0x00000005. Latency is still 33 cycles.
- Backpressure: rsp_ready_i low for 5 cycles in DONE → rsp_valid_o stays 1, result stable, req_ready_o=0, req_valid_i ignored. Then a response handshake, and req_ready_o=1 in the next cycle.
- Reset asserted at cnt=10 of a MUL → outputs at reset values immediately. No rsp_valid_o afterwards. A following MUL 3*3 returns 9 with normal latency.
